voice_ram_arbiter: RTL and testbench
====================================

Name: voice_ram_arbiter

Overview:
- Shares the single-port voice sample RAM (2830 x 32-bit words, 12-bit address) between three requesters:
  - the PDM sampler write path, which cannot stall;
  - the template comparator streaming reads;
  - a host/debug readout port.
- Writes have absolute priority. Reads are round-robin, with an optional comparator burst lock.
- All RAM port signals are registered. Read data is returned with a per-requester valid tag.

Parameters:
- ADDR_W, 12, RAM address width
- DATA_W, 32, RAM data width (4 packed 8-bit samples)
- RD_LAT, 1, RAM read latency in cycles from registered address to ram_rdata valid; legal 1..3
- STALL_W, 16, width of host stall counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- wr_req  in  1  sampler write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ack  out  1  write accepted this cycle
- cmp_req  in  1  comparator read request
- cmp_lock  in  1  hold comparator grant across consecutive requests
- cmp_addr  in  ADDR_W  comparator read address
- cmp_ack  out  1  comparator read accepted this cycle
- cmp_rvalid  out  1  cmp_rdata valid
- cmp_rdata  out  DATA_W  comparator read data
- host_req  in  1  host read request
- host_addr  in  ADDR_W  host read address
- host_ack  out  1  host read accepted this cycle
- host_rvalid  out  1  host_rdata valid
- host_rdata  out  DATA_W  host read data
- ram_wr  out  1  RAM write enable (registered)
- ram_addr  out  ADDR_W  RAM address (registered)
- ram_wdata  out  DATA_W  RAM write data (registered)
- ram_rdata  in  DATA_W  RAM read data
- locked  out  1  arbiter in LOCK_CMP state
- host_stall_cnt  out  STALL_W  saturating count of cycles with host_req=1 and host_ack=0

Behaviour:
- Reset values:
  - all acks, rvalids, ram_wr, locked = 0
  - ram_addr, ram_wdata, cmp_rdata, host_rdata, host_stall_cnt = 0
  - state = IDLE; rr pointer = CMP (host wins the first tie)
- Grant rules (combinational within cycle N; acks are a function of the current request inputs and state):
  - Exactly one ack max per cycle.
  - wr_req=1: wr_ack=1 regardless of state or lock.
  - Else, IDLE:
    - only one reader requesting: that reader is acked;
    - both requesting: the reader not named by the rr pointer is acked, and rr pointer <= the granted reader.
  - Else, LOCK_CMP: only cmp may be acked; host_ack=0 even if cmp_req=0.
- RAM drive (on any ack in cycle N, registered at cycle N+1):
  - ram_addr = acked address.
  - ram_wr = wr_ack; ram_wdata = wr_data when a write is acked.
  - No ack in cycle N: ram_wr=0, ram_addr/ram_wdata hold.
- Read return:
  - A 2-bit tag {cmp,host} is shifted through an RD_LAT+1 deep pipeline.
  - A read acked in cycle N returns at cycle N+1+RD_LAT with the matching rvalid pulsed for one cycle.
  - ram_rdata is registered into the matching rdata register on that same edge; the other rdata register holds.
  - Writes push an empty tag.
- State machine:
  - IDLE -> LOCK_CMP when cmp_ack=1 and cmp_lock=1 in the same cycle.
  - LOCK_CMP -> IDLE on the first cycle cmp_lock=0; host is eligible the cycle after.
  - locked = (state == LOCK_CMP).
  - A write preempting during LOCK_CMP does not exit the lock.
- host_stall_cnt:
  - Increments each cycle host_req=1 and host_ack=0.
  - Saturates at 2^STALL_W-1.
  - Cleared only by rst.
- Boundary conditions:
  - Addresses are passed unmodified; there is no range check, and address 2830+ is the caller's responsibility.
  - All three requesters in the same cycle: write wins, no read is acked, and the rr pointer is unchanged.
  - Requesters must hold req and addr until acked.
  - Reset mid-operation: the tag pipeline is cleared, so no rvalid is produced for reads in flight.
  - Read of the address written in the previous cycle: returns the RAM's behaviour; the arbiter does no forwarding.

Test Plan:
- Single host read, addr 0x005, RD_LAT=1, RAM[5]=0xDEADBEEF:
  - host_ack at cycle 0; ram_addr=5 at cycle 1; host_rvalid=1 with host_rdata=0xDEADBEEF at cycle 2; cmp_rvalid stays 0.
- wr_req, cmp_req and host_req all high for 3 cycles:
  - wr_ack on all 3 cycles; cmp_ack=host_ack=0; host_stall_cnt=3.
- cmp_req and host_req continuously high, no lock:
  - acks alternate host, cmp, host, cmp starting with host after reset.
  - rvalids alternate with correct data tags.
- cmp_lock=1 with cmp_req for 10 cycles, host_req high throughout, one write injected at cycle 4:
  - host_ack=0 for all 10 cycles; wr_ack at cycle 4; locked=1 from cycle 1.
  - After cmp_lock drops, host is acked the next cycle.
- Assert rst with 2 reads in flight (RD_LAT=3):
  - no rvalid after reset; all outputs zero; host_stall_cnt=0.
- host_req held with continuous writes for 70000 cycles, STALL_W=16:
  - host_stall_cnt saturates at 65535 and does not wrap.

Source files
------------

// File: rtl/voice_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// voice_ram_arbiter_if
// Bundles every signal of the voice sample RAM arbiter except clk/rst:
//   - sampler write port    : wr_req, wr_addr, wr_data, wr_ack
//   - comparator read port  : cmp_req, cmp_lock, cmp_addr, cmp_ack,
//                             cmp_rvalid, cmp_rdata
//   - host/debug read port  : host_req, host_addr, host_ack,
//                             host_rvalid, host_rdata
//   - RAM port              : ram_wr, ram_addr, ram_wdata, ram_rdata
//   - status                : locked, host_stall_cnt
// master : the requesters and the RAM (drive requests and ram_rdata)
// slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface voice_ram_arbiter_if #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int STALL_W = 16
);
    logic                wr_req;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_ack;

    logic                cmp_req;
    logic                cmp_lock;
    logic [ADDR_W-1:0]   cmp_addr;
    logic                cmp_ack;
    logic                cmp_rvalid;
    logic [DATA_W-1:0]   cmp_rdata;

    logic                host_req;
    logic [ADDR_W-1:0]   host_addr;
    logic                host_ack;
    logic                host_rvalid;
    logic [DATA_W-1:0]   host_rdata;

    logic                ram_wr;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_rdata;

    logic                locked;
    logic [STALL_W-1:0]  host_stall_cnt;

    modport master (
        output wr_req, wr_addr, wr_data,
        output cmp_req, cmp_lock, cmp_addr,
        output host_req, host_addr,
        output ram_rdata,
        input  wr_ack, cmp_ack, cmp_rvalid, cmp_rdata,
        input  host_ack, host_rvalid, host_rdata,
        input  ram_wr, ram_addr, ram_wdata,
        input  locked, host_stall_cnt
    );

    modport slave (
        input  wr_req, wr_addr, wr_data,
        input  cmp_req, cmp_lock, cmp_addr,
        input  host_req, host_addr,
        input  ram_rdata,
        output wr_ack, cmp_ack, cmp_rvalid, cmp_rdata,
        output host_ack, host_rvalid, host_rdata,
        output ram_wr, ram_addr, ram_wdata,
        output locked, host_stall_cnt
    );
endinterface

// File: rtl/voice_ram_arbiter.sv
// ---------------------------------------------------------------------------
// voice_ram_arbiter
// Shares the single-port voice sample RAM between the PDM sampler (writes,
// never stalled), the template comparator (streaming reads, optional burst
// lock) and the host/debug readout port.
// Ports:
//   clk  - clock
//   rst  - asynchronous, active-high reset
//   bus  - voice_ram_arbiter_if.slave carrying all request/ack, RAM and
//          status signals
// Acks are combinational from the current requests and arbiter state; the
// RAM port, read returns and status are registered.
// ---------------------------------------------------------------------------
module voice_ram_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int RD_LAT  = 1,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    voice_ram_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_LOCK_CMP = 1'b1
    } state_t;

    // Round-robin pointer names the reader granted most recently on a tie.
    localparam logic RR_CMP  = 1'b0;
    localparam logic RR_HOST = 1'b1;

    localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};
    localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic                 rr_q, rr_d;

    logic                 wr_grant;
    logic                 cmp_grant;
    logic                 host_grant;

    logic                 ram_wr_q, ram_wr_d;
    logic [ADDR_W-1:0]    ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]    ram_wdata_q, ram_wdata_d;

    // Tag {cmp,host} per stage; the rvalid flops form the final stage.
    logic [RD_LAT-1:0][1:0] tag_q, tag_d;
    logic                 cmp_rvalid_q, cmp_rvalid_d;
    logic                 host_rvalid_q, host_rvalid_d;
    logic [DATA_W-1:0]    cmp_rdata_q, cmp_rdata_d;
    logic [DATA_W-1:0]    host_rdata_q, host_rdata_d;

    logic [STALL_W-1:0]   stall_q, stall_d;

    // Grant selection, round-robin update and lock state transitions.
    always_comb begin
        wr_grant   = 1'b0;
        cmp_grant  = 1'b0;
        host_grant = 1'b0;
        rr_d       = rr_q;
        state_d    = state_q;

        if (bus.wr_req) begin
            // Writes cannot stall; readers simply wait, pointer untouched.
            wr_grant = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmp_req && bus.host_req) begin
                        if (rr_q == RR_CMP) begin
                            host_grant = 1'b1;
                            rr_d       = RR_HOST;
                        end else begin
                            cmp_grant  = 1'b1;
                            rr_d       = RR_CMP;
                        end
                    end else if (bus.cmp_req) begin
                        cmp_grant = 1'b1;
                    end else if (bus.host_req) begin
                        host_grant = 1'b1;
                    end else begin
                        host_grant = 1'b0;
                    end
                end
                ST_LOCK_CMP: begin
                    // Host is shut out for the whole lock, even on idle cycles.
                    cmp_grant = bus.cmp_req;
                end
                default: begin
                    cmp_grant  = 1'b0;
                    host_grant = 1'b0;
                end
            endcase
        end

        // Lock exit depends only on cmp_lock, so a write never breaks a burst.
        case (state_q)
            ST_IDLE: begin
                if (cmp_grant && bus.cmp_lock) begin
                    state_d = ST_LOCK_CMP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCK_CMP: begin
                if (!bus.cmp_lock) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOCK_CMP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // RAM port next values; address and write data hold when nothing is acked.
    always_comb begin
        ram_wr_d    = wr_grant;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (wr_grant) begin
            ram_addr_d  = bus.wr_addr;
            ram_wdata_d = bus.wr_data;
        end else if (cmp_grant) begin
            ram_addr_d  = bus.cmp_addr;
        end else if (host_grant) begin
            ram_addr_d  = bus.host_addr;
        end else begin
            ram_addr_d  = ram_addr_q;
        end
    end

    // Read-return tag pipeline and capture of ram_rdata into the owner's register.
    always_comb begin
        tag_d    = tag_q;
        tag_d[0] = {cmp_grant, host_grant};
        for (int k = 1; k < RD_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end

        cmp_rvalid_d  = tag_q[RD_LAT-1][1];
        host_rvalid_d = tag_q[RD_LAT-1][0];

        if (tag_q[RD_LAT-1][1]) begin
            cmp_rdata_d = bus.ram_rdata;
        end else begin
            cmp_rdata_d = cmp_rdata_q;
        end

        if (tag_q[RD_LAT-1][0]) begin
            host_rdata_d = bus.ram_rdata;
        end else begin
            host_rdata_d = host_rdata_q;
        end
    end

    // Saturating count of cycles the host waited.
    always_comb begin
        if (bus.host_req && !host_grant && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + STALL_ONE;
        end else begin
            stall_d = stall_q;
        end
    end

    // State, RAM port, read pipeline and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rr_q          <= RR_CMP;
            ram_wr_q      <= 1'b0;
            ram_addr_q    <= {ADDR_W{1'b0}};
            ram_wdata_q   <= {DATA_W{1'b0}};
            tag_q         <= {(2*RD_LAT){1'b0}};
            cmp_rvalid_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
            cmp_rdata_q   <= {DATA_W{1'b0}};
            host_rdata_q  <= {DATA_W{1'b0}};
            stall_q       <= {STALL_W{1'b0}};
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            ram_wr_q      <= ram_wr_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            tag_q         <= tag_d;
            cmp_rvalid_q  <= cmp_rvalid_d;
            host_rvalid_q <= host_rvalid_d;
            cmp_rdata_q   <= cmp_rdata_d;
            host_rdata_q  <= host_rdata_d;
            stall_q       <= stall_d;
        end
    end

    assign bus.wr_ack         = wr_grant;
    assign bus.cmp_ack        = cmp_grant;
    assign bus.host_ack       = host_grant;
    assign bus.ram_wr         = ram_wr_q;
    assign bus.ram_addr       = ram_addr_q;
    assign bus.ram_wdata      = ram_wdata_q;
    assign bus.cmp_rvalid     = cmp_rvalid_q;
    assign bus.cmp_rdata      = cmp_rdata_q;
    assign bus.host_rvalid    = host_rvalid_q;
    assign bus.host_rdata     = host_rdata_q;
    assign bus.locked         = (state_q == ST_LOCK_CMP);
    assign bus.host_stall_cnt = stall_q;

endmodule

// File: tb/tb_voice_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_voice_ram_arbiter
// Directed bench for voice_ram_arbiter. Two instances share clk, rst and the
// requester inputs: u_dut1 (RD_LAT=1) behind a combinational-read RAM model
// and u_dut3 (RD_LAT=3) behind a RAM model with two extra register stages.
// RAM contents are a fixed function of address (ram_val).
// ---------------------------------------------------------------------------
module tb_voice_ram_arbiter;

    logic clk;
    logic rst;

    int total;
    int bad;

    voice_ram_arbiter_if #(.ADDR_W(12), .DATA_W(32), .STALL_W(16)) if1 ();
    voice_ram_arbiter_if #(.ADDR_W(12), .DATA_W(32), .STALL_W(16)) if3 ();

    voice_ram_arbiter #(.ADDR_W(12), .DATA_W(32), .RD_LAT(1), .STALL_W(16)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    voice_ram_arbiter #(.ADDR_W(12), .DATA_W(32), .RD_LAT(3), .STALL_W(16)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3)
    );

    function automatic logic [31:0] ram_val(input logic [11:0] a);
        if (a == 12'h005) return 32'hDEADBEEF;
        else return {8'h5A, 12'h000, a};
    endfunction

    // RAM with RD_LAT=1: data valid in the cycle the registered address is shown.
    assign if1.ram_rdata = ram_val(if1.ram_addr);

    // RAM with RD_LAT=3: two more register stages.
    logic [31:0] r3a, r3b;
    always @(posedge clk) begin
        r3a <= ram_val(if3.ram_addr);
        r3b <= r3a;
    end
    assign if3.ram_rdata = r3b;

    assign if3.wr_req    = if1.wr_req;
    assign if3.wr_addr   = if1.wr_addr;
    assign if3.wr_data   = if1.wr_data;
    assign if3.cmp_req   = if1.cmp_req;
    assign if3.cmp_lock  = if1.cmp_lock;
    assign if3.cmp_addr  = if1.cmp_addr;
    assign if3.host_req  = if1.host_req;
    assign if3.host_addr = if1.host_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        if1.wr_req    = 1'b0;
        if1.cmp_req   = 1'b0;
        if1.cmp_lock  = 1'b0;
        if1.host_req  = 1'b0;
    endtask

    task automatic check_zero(input string who, input int sel);
        if (sel == 1) begin
            check({who, "_acks"},   32'({if1.wr_ack, if1.cmp_ack, if1.host_ack}), 32'd0);
            check({who, "_rvalid"}, 32'({if1.cmp_rvalid, if1.host_rvalid}), 32'd0);
            check({who, "_ram_wr"}, 32'(if1.ram_wr), 32'd0);
            check({who, "_ram_addr"}, 32'(if1.ram_addr), 32'd0);
            check({who, "_ram_wdata"}, if1.ram_wdata, 32'd0);
            check({who, "_cmp_rdata"}, if1.cmp_rdata, 32'd0);
            check({who, "_host_rdata"}, if1.host_rdata, 32'd0);
            check({who, "_locked"}, 32'(if1.locked), 32'd0);
            check({who, "_stall"}, 32'(if1.host_stall_cnt), 32'd0);
        end else begin
            check({who, "_rvalid3"}, 32'({if3.cmp_rvalid, if3.host_rvalid}), 32'd0);
            check({who, "_ram_addr3"}, 32'(if3.ram_addr), 32'd0);
            check({who, "_ram_wdata3"}, if3.ram_wdata, 32'd0);
            check({who, "_cmp_rdata3"}, if3.cmp_rdata, 32'd0);
            check({who, "_host_rdata3"}, if3.host_rdata, 32'd0);
            check({who, "_stall3"}, 32'(if3.host_stall_cnt), 32'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle_inputs();
        if1.wr_addr   = 12'h000;
        if1.wr_data   = 32'h0;
        if1.cmp_addr  = 12'h000;
        if1.host_addr = 12'h000;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check_zero("rst", 1);
        check_zero("rst", 3);
        @(negedge clk);
        rst = 1'b0;

        // Single host read of address 5
        @(negedge clk);
        if1.host_req = 1'b1; if1.host_addr = 12'h005;
        #1;
        check("t1_host_ack", 32'(if1.host_ack), 32'd1);
        check("t1_cmp_ack",  32'(if1.cmp_ack),  32'd0);
        @(negedge clk);
        if1.host_req = 1'b0;
        #1;
        check("t1_ram_addr", 32'(if1.ram_addr), 32'h005);
        check("t1_ram_wr",   32'(if1.ram_wr),   32'd0);
        check("t1_early_rvalid", 32'(if1.host_rvalid), 32'd0);
        @(negedge clk);
        #1;
        check("t1_host_rvalid", 32'(if1.host_rvalid), 32'd1);
        check("t1_host_rdata",  if1.host_rdata, 32'hDEADBEEF);
        check("t1_cmp_rvalid",  32'(if1.cmp_rvalid), 32'd0);
        @(negedge clk);
        #1;
        check("t1_rvalid_pulse", 32'(if1.host_rvalid), 32'd0);

        // All three requesting for 3 cycles: write always wins
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if1.wr_req = 1'b1; if1.cmp_req = 1'b1; if1.host_req = 1'b1;
            if1.wr_addr = 12'h100 + 12'(i);
            if1.wr_data = 32'hCAFE0000 + 32'(i);
            if1.cmp_addr = 12'h040; if1.host_addr = 12'h050;
            #1;
            check("t2_wr_ack",   32'(if1.wr_ack),   32'd1);
            check("t2_cmp_ack",  32'(if1.cmp_ack),  32'd0);
            check("t2_host_ack", 32'(if1.host_ack), 32'd0);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        check("t2_ram_wr",    32'(if1.ram_wr),   32'd1);
        check("t2_ram_addr",  32'(if1.ram_addr), 32'h102);
        check("t2_ram_wdata", if1.ram_wdata,     32'hCAFE0002);
        check("t2_stall",     32'(if1.host_stall_cnt), 32'd3);
        check("t2_no_rvalid", 32'({if1.cmp_rvalid, if1.host_rvalid}), 32'd0);
        @(negedge clk);
        #1;
        check("t2_ram_wr_off",  32'(if1.ram_wr),   32'd0);
        check("t2_ram_addr_hold", 32'(if1.ram_addr), 32'h102);

        // Both readers continuously: alternate starting with host
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if1.cmp_req  = (i < 4);
            if1.host_req = (i < 4);
            if1.cmp_addr = 12'h010; if1.host_addr = 12'h020;
            #1;
            if (i < 4) begin
                check("t3_host_ack", 32'(if1.host_ack), 32'(i % 2 == 0));
                check("t3_cmp_ack",  32'(if1.cmp_ack),  32'(i % 2 == 1));
            end
            if (i >= 2) begin
                check("t3_host_rvalid", 32'(if1.host_rvalid), 32'(i % 2 == 0));
                check("t3_cmp_rvalid",  32'(if1.cmp_rvalid),  32'(i % 2 == 1));
            end
            if (i == 3) begin
                check("t3_host_rdata", if1.host_rdata, ram_val(12'h020));
                check("t3_cmp_rdata",  if1.cmp_rdata,  ram_val(12'h010));
            end
            if (i == 5) check("t3_stall", 32'(if1.host_stall_cnt), 32'd5);
        end

        // One tie so the pointer names host, then the locked comparator burst
        @(negedge clk);
        if1.cmp_req = 1'b1; if1.host_req = 1'b1;
        if1.cmp_addr = 12'h011; if1.host_addr = 12'h021;
        #1;
        check("t4_pre_host_ack", 32'(if1.host_ack), 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if1.cmp_addr  = 12'h012;
            if1.wr_addr   = 12'h200;
            if1.wr_data   = 32'h12345678;
            if1.host_req  = 1'b1;
            if1.cmp_req   = (i < 10);
            if1.cmp_lock  = (i < 10);
            if1.wr_req    = (i == 4);
            #1;
            if (i < 10) begin
                check("t4_host_ack", 32'(if1.host_ack), 32'd0);
                check("t4_wr_ack",   32'(if1.wr_ack),   32'(i == 4));
                check("t4_cmp_ack",  32'(if1.cmp_ack),  32'(i != 4));
                check("t4_locked",   32'(if1.locked),   32'(i >= 1));
            end else if (i == 10) begin
                check("t4_drop_host_ack", 32'(if1.host_ack), 32'd0);
                check("t4_drop_locked",   32'(if1.locked),   32'd1);
            end else begin
                check("t4_after_locked",   32'(if1.locked),   32'd0);
                check("t4_after_host_ack", 32'(if1.host_ack), 32'd1);
                check("t4_stall", 32'(if1.host_stall_cnt), 32'd16);
            end
        end
        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);

        // Out-of-range address passes through unmodified
        if1.cmp_req = 1'b1; if1.cmp_addr = 12'hB10;
        #1;
        check("t5_cmp_ack", 32'(if1.cmp_ack), 32'd1);
        @(negedge clk);
        if1.cmp_req = 1'b0;
        #1;
        check("t5_ram_addr", 32'(if1.ram_addr), 32'hB10);
        @(negedge clk);
        #1;
        check("t5_cmp_rvalid", 32'(if1.cmp_rvalid), 32'd1);
        check("t5_cmp_rdata",  if1.cmp_rdata, ram_val(12'hB10));
        check("t5_host_rvalid", 32'(if1.host_rvalid), 32'd0);

        // Reset with two reads in flight in the RD_LAT=3 instance
        @(negedge clk);
        if1.host_req = 1'b1; if1.host_addr = 12'h030;
        #1;
        check("t6_ack0", 32'(if3.host_ack), 32'd1);
        @(negedge clk);
        if1.host_addr = 12'h031;
        #1;
        check("t6_ack1", 32'(if3.host_ack), 32'd1);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        check_zero("t6_rst", 1);
        check_zero("t6_rst", 3);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            check("t6_rvalid3", 32'({if3.cmp_rvalid, if3.host_rvalid}), 32'd0);
            check("t6_rvalid1", 32'({if1.cmp_rvalid, if1.host_rvalid}), 32'd0);
        end

        // Host starved by continuous writes: counter saturates
        @(negedge clk);
        if1.wr_req = 1'b1; if1.wr_addr = 12'h300; if1.wr_data = 32'h0000_0300;
        if1.host_req = 1'b1; if1.host_addr = 12'h060;
        #1;
        check("t7_wr_ack",   32'(if1.wr_ack),   32'd1);
        check("t7_host_ack", 32'(if1.host_ack), 32'd0);
        repeat (65534) @(negedge clk);
        #1;
        check("t7_stall_65534", 32'(if1.host_stall_cnt), 32'd65534);
        repeat (2) @(negedge clk);
        #1;
        check("t7_stall_sat", 32'(if1.host_stall_cnt), 32'd65535);
        repeat (70000 - 65536) @(negedge clk);
        #1;
        check("t7_stall_hold",  32'(if1.host_stall_cnt), 32'd65535);
        check("t7_stall_hold3", 32'(if3.host_stall_cnt), 32'd65535);
        check("t7_host_ack_end", 32'(if1.host_ack), 32'd0);
        @(negedge clk);
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
